// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences register load enables,
// the register-file write and a single-request memory handshake with timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_en,
  output logic       pc_src,
  output logic       ir_en,
  output logic       alu_en,
  output logic       mdr_en,
  output logic       rf_we,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Last wait-counter value before a stalled request traps (unused when TIMEOUT is 0).
  localparam int               LIMIT   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT_C = LIMIT[CNT_W-1:0];

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             is_legal;
  logic             timeout_hit;

  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == LIMIT_C) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    ir_en     = 1'b0;
    alu_en    = 1'b0;
    mdr_en    = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_d = S_HALT;
        end else if (is_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEM;
        end else if (opcode == OP_BRANCH) begin
          pc_en   = 1'b1;
          pc_src  = branch_taken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_en  = 1'b1;
            state_d = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        pc_src  = (opcode == OP_JAL) || (opcode == OP_JALR);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_TRAP: state_d = state_q;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Reset aborts any in-flight handshake within the same cycle.
    if (rst) begin
      state_d    = S_FETCH;
      wait_cnt_d = '0;
      illegal_d  = 1'b0;
      bus_err_d  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 1'b0;
      ir_en      = 1'b0;
      alu_en     = 1'b0;
      mdr_en     = 1'b0;
      rf_we      = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign halted  = (state_q == S_HALT) && !rst;
  assign illegal = illegal_q && !rst;
  assign bus_err = bus_err_q && !rst;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (TIMEOUT=4): opcode classes,
// memory stalls, timeout boundary, halt, illegal trap and mid-handshake reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, pc_en, pc_src, ir_en, alu_en, mdr_en;
  logic       rf_we, retire, halted, illegal, bus_err;
  logic [2:0] state;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [6:0] ADD = 7'h33, LOAD = 7'h03, STORE = 7'h23, BR = 7'h63;
  localparam logic [6:0] JAL = 7'h6F, SYS = 7'h73, BAD = 7'h00;

  localparam logic [11:0] F_REQ = 12'h800, F_WE  = 12'h400, F_PCEN = 12'h200;
  localparam logic [11:0] F_PCS = 12'h100, F_IR  = 12'h080, F_ALU  = 12'h040;
  localparam logic [11:0] F_MDR = 12'h020, F_RF  = 12'h010, F_RET  = 12'h008;
  localparam logic [11:0] F_HLT = 12'h004, F_ILL = 12'h002, F_BERR = 12'h001;
  localparam logic [11:0] NONE  = 12'h000;

  logic [14:0] observed;
  assign observed = {state, mem_req, mem_we, pc_en, pc_src, ir_en, alu_en, mdr_en,
                     rf_we, retire, halted, illegal, bus_err};

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_en(pc_en),
    .pc_src(pc_src), .ir_en(ir_en), .alu_en(alu_en), .mdr_en(mdr_en),
    .rf_we(rf_we), .retire(retire), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [6:0] op,
                               input logic bt, input logic rdy);
    rst          = r;
    opcode       = op;
    branch_taken = bt;
    mem_ready    = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] obs,
                             input logic [14:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got state=%0d flags=%03h, want state=%0d flags=%03h",
               tag, obs[14:12], obs[11:0], exp[14:12], exp[11:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check combinational/registered outputs, advance.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic bt, input logic rdy, input logic [2:0] st,
                      input logic [11:0] flags);
    applyStimulus(r, op, bt, rdy);
    checkOutput(tag, observed, {st, flags});
    tick();
  endtask

  initial begin
    applyStimulus(1'b1, BAD, 1'b0, 1'b0);
    tick();
    step("reset", 1'b1, BAD, 1'b1, 1'b1, 3'd0, NONE);
    step("first_fetch_stall", 1'b0, ADD, 1'b0, 1'b0, 3'd0, F_REQ);

    step("add_fetch", 1'b0, ADD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("add_decode", 1'b0, ADD, 1'b0, 1'b1, 3'd1, NONE);
    step("add_exec", 1'b0, ADD, 1'b0, 1'b1, 3'd2, F_ALU);
    step("add_wb", 1'b0, ADD, 1'b0, 1'b1, 3'd4, F_RF | F_PCEN | F_RET);

    step("load_fetch", 1'b0, ADD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("load_decode", 1'b0, LOAD, 1'b0, 1'b0, 3'd1, NONE);
    step("load_exec", 1'b0, LOAD, 1'b0, 1'b0, 3'd2, F_ALU);
    for (int i = 0; i < 3; i++) step("load_mem_wait", 1'b0, LOAD, 1'b0, 1'b0, 3'd3, F_REQ);
    step("load_mem_ready", 1'b0, LOAD, 1'b0, 1'b1, 3'd3, F_REQ | F_MDR);
    step("load_wb", 1'b0, LOAD, 1'b0, 1'b0, 3'd4, F_RF | F_PCEN | F_RET);

    step("store_fetch", 1'b0, LOAD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("store_decode", 1'b0, STORE, 1'b0, 1'b1, 3'd1, NONE);
    step("store_exec", 1'b0, STORE, 1'b0, 1'b1, 3'd2, F_ALU);
    step("store_mem", 1'b0, STORE, 1'b0, 1'b1, 3'd3, F_REQ | F_WE | F_PCEN | F_RET);

    step("br_fetch", 1'b0, STORE, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("br_decode", 1'b0, BR, 1'b1, 1'b1, 3'd1, NONE);
    step("br_exec", 1'b0, BR, 1'b1, 1'b1, 3'd2, F_ALU | F_PCEN | F_PCS | F_RET);

    step("jal_fetch", 1'b0, BR, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("jal_decode", 1'b0, JAL, 1'b0, 1'b0, 3'd1, NONE);
    step("jal_exec", 1'b0, JAL, 1'b0, 1'b0, 3'd2, F_ALU);
    step("jal_wb", 1'b0, JAL, 1'b0, 1'b0, 3'd4, F_RF | F_PCEN | F_PCS | F_RET);

    // Ready arriving in the last allowed wait cycle must be accepted.
    for (int i = 0; i < 3; i++) step("fetch_wait", 1'b0, JAL, 1'b0, 1'b0, 3'd0, F_REQ);
    step("fetch_ready_c4", 1'b0, JAL, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("sys_decode", 1'b0, SYS, 1'b0, 1'b0, 3'd1, NONE);
    for (int i = 0; i < 20; i++)
      step("halt_hold", 1'b0, 7'($urandom), 1'($urandom), 1'($urandom), 3'd5, F_HLT);
    step("rst_from_halt", 1'b1, BAD, 1'b0, 1'b1, 3'd5, NONE);

    for (int i = 0; i < 4; i++) step("timeout_wait", 1'b0, ADD, 1'b0, 1'b0, 3'd0, F_REQ);
    for (int i = 0; i < 5; i++)
      step("timeout_trap", 1'b0, 7'($urandom), 1'($urandom), 1'($urandom), 3'd6, F_BERR);
    step("rst_from_berr", 1'b1, BAD, 1'b0, 1'b0, 3'd6, NONE);

    step("ill_fetch", 1'b0, ADD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("ill_decode", 1'b0, BAD, 1'b0, 1'b1, 3'd1, NONE);
    for (int i = 0; i < 20; i++)
      step("ill_hold", 1'b0, 7'($urandom), 1'($urandom), 1'($urandom), 3'd6, F_ILL);
    step("rst_from_ill", 1'b1, BAD, 1'b0, 1'b0, 3'd6, NONE);

    step("abort_fetch", 1'b0, ADD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);
    step("abort_decode", 1'b0, LOAD, 1'b0, 1'b0, 3'd1, NONE);
    step("abort_exec", 1'b0, LOAD, 1'b0, 1'b0, 3'd2, F_ALU);
    for (int i = 0; i < 2; i++) step("abort_mem_wait", 1'b0, LOAD, 1'b0, 1'b0, 3'd3, F_REQ);
    step("abort_rst", 1'b1, LOAD, 1'b0, 1'b1, 3'd3, NONE);
    for (int i = 0; i < 2; i++) step("abort_refetch", 1'b0, LOAD, 1'b0, 1'b0, 3'd0, F_REQ);
    step("abort_refetch_rdy", 1'b0, LOAD, 1'b0, 1'b1, 3'd0, F_REQ | F_IR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multi-cycle RV32I core. It sequences the load enables of the core's architectural and pipeline registers (PC, IR, ALU-out, MDR) and the register-file write, and it drives a single-request memory handshake. Decode is at opcode level only; the datapath handles funct3/funct7 and rd==0 suppression. Illegal opcodes trap, memory stalls are bounded by a timeout, and SYSTEM opcodes halt the core.

Parameters:
TIMEOUT, 16, maximum cycles a memory request may wait for mem_ready; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
opcode  input  7  IR[6:0]; valid from DECODE onward.
branch_taken  input  1  branch comparison result; sampled in EXECUTE.
mem_ready  input  1  memory has completed the current request.
mem_req  output  1  memory request active.
mem_we  output  1  1 = write request (store), 0 = read request.
pc_en  output  1  PC register load enable.
pc_src  output  1  0 = PC+4, 1 = ALU target.
ir_en  output  1  IR load enable.
alu_en  output  1  ALU-out register load enable.
mdr_en  output  1  memory data register load enable.
rf_we  output  1  register-file write enable.
retire  output  1  one-cycle pulse per completed instruction.
halted  output  1  core halted after a SYSTEM opcode.
illegal  output  1  illegal-opcode trap.
bus_err  output  1  memory timeout trap.
state  output  3  current state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, TRAP=6.
- While rst=1: next state is FETCH, wait_cnt=0, illegal=bus_err=halted=0, and every enable, mem_req and retire output is 0 in that cycle. A reset asserted in any state, including mid-handshake, aborts the operation.
- First cycle after reset release: state=FETCH, mem_req=1.
- Enables, mem_req and retire are combinational from the state and current inputs; all transitions are registered.
- FETCH: mem_req=1, mem_we=0.
  - If mem_ready=1 that cycle: ir_en=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no enables asserted. Next state by opcode:
  - 0110011 (OP), 0010011 (OP-IMM), 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR), 1100011 (BRANCH), 0000011 (LOAD), 0100011 (STORE): go to EXECUTE.
  - 1110011 (SYSTEM): go to HALT.
  - Any other opcode: go to TRAP with illegal=1.
- EXECUTE: alu_en=1.
  - LOAD or STORE: go to MEM.
  - BRANCH: pc_en=1, pc_src=branch_taken, retire=1, go to FETCH.
  - All other opcodes: go to WRITEBACK.
- MEM: mem_req=1, mem_we=1 for STORE and 0 for LOAD. On mem_ready=1:
  - LOAD: mdr_en=1, go to WRITEBACK.
  - STORE: pc_en=1, pc_src=0, retire=1, go to FETCH.
- WRITEBACK: rf_we=1, pc_en=1, pc_src=1 for JAL/JALR and 0 otherwise, retire=1, go to FETCH.
- HALT: all enables and mem_req are 0, halted=1; the FSM stays here until rst.
- TRAP: all enables and mem_req are 0; illegal or bus_err stays sticky; the FSM stays here until rst.
- Wait counter:
  - wait_cnt clears on every state change and increments each FETCH/MEM cycle with mem_ready=0.
  - If TIMEOUT>0 and wait_cnt==TIMEOUT-1 with mem_ready=0, go to TRAP with bus_err=1.
  - Ready in request cycle k≤TIMEOUT is accepted; no ready by cycle TIMEOUT traps.
  - With TIMEOUT=0 the FSM waits indefinitely.
- mem_req stays high continuously while waiting. It drops for at least one cycle between requests, since DECODE/EXECUTE/WRITEBACK separate them, except in the STORE→FETCH case, where a new read follows immediately with mem_we falling to 0.
- Latencies with zero-wait memory, counted FETCH-entry to FETCH-entry:
  - BRANCH: 3 cycles.
  - ALU/JAL/JALR/LUI/AUIPC: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Simultaneous events: rst has priority over all of them. A mem_ready in the same cycle as the timeout boundary is accepted; no trap occurs.
- Inputs are ignored in HALT and TRAP.

Test Plan:
- Reset, then opcode=0110011 (add x3,x1,x2 = 0x002081B3) with mem_ready tied to 1 → state sequence 0,1,2,4,0; ir_en pulses in cycle 0, alu_en in cycle 2, rf_we/pc_en/retire in cycle 3 with pc_src=0.
- LOAD (0x0000A183) with ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_req=1 and mem_we=0, mdr_en pulses in the ready cycle, then WRITEBACK with rf_we=1.
- STORE (0x0030A023) then BRANCH (opcode 1100011) with branch_taken=1 → the store ends with mem_we=1 and pc_en=1/pc_src=0 in MEM; the branch ends in EXECUTE with pc_en=1, pc_src=1, retire=1, and 3-cycle latency.
- TIMEOUT=4, mem_ready held 0 in FETCH → 4 FETCH cycles, then state=6, bus_err=1, mem_req=0 permanently. Repeating with ready in cycle 4 → no trap.
- Opcode 0000000 → TRAP with illegal=1. Opcode 1110011 (ecall 0x00000073) → HALT with halted=1. In both cases no enables fire for 20 further cycles.
- rst asserted for 1 cycle mid-MEM wait on a load → all outputs 0 that cycle, next state FETCH with mem_req=1 and mem_we=0, and mdr_en/rf_we never fire for the aborted load.
